writeback_retire_unit: RTL and testbench

- Parametrised successor to the combinational writeback stage; sits after the memory stage and drives the register-file write port.
- Adds a valid/ready handshake, registered write output with one-cycle latency, and a wait state for late load data.
- Adds byte-offset load alignment, x0 write suppression, a forwarding/hazard view, and a retired-instruction counter.

---
 rtl/writeback_retire_unit_pkg.sv | 63 ++++++
 rtl/writeback_retire_unit_load_extender.sv | 46 ++++
 rtl/writeback_retire_unit.sv | 175 +++++++++++++++++
 tb/tb_writeback_retire_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_retire_unit_pkg.sv
// -----------------------------------------------------------------------------
// writeback_retire_unit_pkg
// Shared pipeline definitions used by the writeback/retire stage:
//   - RV32 major opcode constants (OPCODE_*)
//   - load funct3 encodings (FUNCT3_LB/LH/LW/LBU/LHU)
//   - default register-file geometry (REGISTER_WIDTH / REGISTER_DEPTH)
//   - helpers that classify an opcode's writeback behaviour
// -----------------------------------------------------------------------------
package writeback_retire_unit_pkg;

  localparam int BYTE_WIDTH     = 8;
  localparam int REGISTER_WIDTH = 32;
  localparam int REGISTER_DEPTH = 32;

  localparam logic [6:0] OPCODE_LOAD       = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE      = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH     = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL        = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR       = 7'b1100111;
  localparam logic [6:0] OPCODE_ARITHMETIC = 7'b0110011;
  localparam logic [6:0] OPCODE_ARITH_IMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI        = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC      = 7'b0010111;
  localparam logic [6:0] OPCODE_SYSTEM     = 7'b1110011;
  localparam logic [6:0] OPCODE_FENCE      = 7'b0001111;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  // Source of the value written back for a retiring instruction.
  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LINK = 2'd1,
    SRC_LOAD = 2'd2,
    SRC_NONE = 2'd3
  } wb_src_e;

  // Classify an opcode by where its writeback value comes from.
  // SRC_NONE covers stores, branches, system, fence and unknown opcodes.
  function automatic wb_src_e opcode_wb_src(input logic [6:0] opcode);
    wb_src_e src;
    case (opcode)
      OPCODE_ARITHMETIC,
      OPCODE_ARITH_IMM,
      OPCODE_LUI,
      OPCODE_AUIPC:      src = SRC_ALU;
      OPCODE_JAL,
      OPCODE_JALR:       src = SRC_LINK;
      OPCODE_LOAD:       src = SRC_LOAD;
      default:           src = SRC_NONE;
    endcase
    return src;
  endfunction

  // True when the opcode architecturally writes rd.
  function automatic logic opcode_writes_rd(input logic [6:0] opcode);
    return (opcode_wb_src(opcode) != SRC_NONE);
  endfunction

endpackage

// File: rtl/writeback_retire_unit_load_extender.sv
// -----------------------------------------------------------------------------
// writeback_retire_unit_load_extender
// Combinational load alignment and extension for any load path.
// Ports:
//   raw_i    [DATA_WIDTH-1:0]  raw memory read word
//   offset_i [1:0]             load address bits [1:0]
//   funct3_i [2:0]             load width / signedness select
//   data_o   [DATA_WIDTH-1:0]  aligned, extended load value
// Alignment acts on the low 32 bits of the raw word. A reserved funct3
// passes the raw word through untouched.
// -----------------------------------------------------------------------------
module writeback_retire_unit_load_extender
  import writeback_retire_unit_pkg::*;
#(
  parameter int DATA_WIDTH = REGISTER_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] raw_i,
  input  logic [1:0]            offset_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [31:0]           low_word_s;
  logic [BYTE_WIDTH-1:0] byte_s;
  logic [15:0]           half_s;

  assign low_word_s = raw_i[31:0];
  // Byte lane chosen by the full offset; halfword lane uses offset[1] only.
  assign byte_s     = low_word_s[{offset_i, 3'b000} +: BYTE_WIDTH];
  assign half_s     = low_word_s[{offset_i[1], 4'b0000} +: 16];

  // Select width and extension by funct3.
  always_comb begin
    data_o = raw_i;
    case (funct3_i)
      FUNCT3_LB:  data_o = DATA_WIDTH'($signed(byte_s));
      FUNCT3_LH:  data_o = DATA_WIDTH'($signed(half_s));
      // Word loads sign-extend when the datapath is wider than 32 bits.
      FUNCT3_LW:  data_o = DATA_WIDTH'($signed(low_word_s));
      FUNCT3_LBU: data_o = DATA_WIDTH'(byte_s);
      FUNCT3_LHU: data_o = DATA_WIDTH'(half_s);
      default:    data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/writeback_retire_unit.sv
// -----------------------------------------------------------------------------
// writeback_retire_unit
// Writeback/retire stage after the memory stage. Accepts one instruction per
// cycle through a valid/ready handshake, waits for late load data in
// WAIT_MEM, and drives a registered register-file write one cycle after
// completion, plus a matching forwarding view and a retired-instruction count.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_tvalid / s_tready      upstream handshake (ready only in IDLE)
//   s_opcode, s_funct3, s_rd instruction fields
//   s_alu_result, s_link_addr candidate write values
//   s_mem_byte_offset, s_mem_data, s_mem_data_valid   load data path
//   rf_we, rf_waddr, rf_wdata register-file write port (registered)
//   bypass_valid/rd/data      forwarding view of the write port
//   pending_load, pending_rd  load waiting for memory data
//   retired_count             retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module writeback_retire_unit
  import writeback_retire_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = REGISTER_WIDTH,
  parameter int REG_ADDR_WIDTH = $clog2(REGISTER_DEPTH),
  parameter int COUNTER_WIDTH  = 64,
  parameter int BYPASS_ENABLE  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic [6:0]                s_opcode,
  input  logic [2:0]                s_funct3,
  input  logic [REG_ADDR_WIDTH-1:0] s_rd,
  input  logic [DATA_WIDTH-1:0]     s_alu_result,
  input  logic [DATA_WIDTH-1:0]     s_link_addr,
  input  logic [1:0]                s_mem_byte_offset,
  input  logic [DATA_WIDTH-1:0]     s_mem_data,
  input  logic                      s_mem_data_valid,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      bypass_valid,
  output logic [REG_ADDR_WIDTH-1:0] bypass_rd,
  output logic [DATA_WIDTH-1:0]     bypass_data,
  output logic                      pending_load,
  output logic [REG_ADDR_WIDTH-1:0] pending_rd,
  output logic [COUNTER_WIDTH-1:0]  retired_count
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_MEM = 1'b1;

  localparam logic [REG_ADDR_WIDTH-1:0] RD_ZERO = {REG_ADDR_WIDTH{1'b0}};

  logic [0:0]                state_q,      state_d;
  logic [REG_ADDR_WIDTH-1:0] cap_rd_q,     cap_rd_d;
  logic [2:0]                cap_funct3_q, cap_funct3_d;
  logic [1:0]                cap_offset_q, cap_offset_d;
  logic                      rf_we_q,      rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q,   rf_waddr_d;
  logic [DATA_WIDTH-1:0]     rf_wdata_q,   rf_wdata_d;
  logic [COUNTER_WIDTH-1:0]  count_q,      count_d;

  logic                      waiting_s;
  logic [1:0]                ext_offset_s;
  logic [2:0]                ext_funct3_s;
  logic [DATA_WIDTH-1:0]     ext_data_s;

  assign waiting_s = (state_q == ST_WAIT_MEM);

  // A waiting load aligns with its captured fields; the live fields by then
  // belong to the next instruction the upstream is holding.
  assign ext_offset_s = waiting_s ? cap_offset_q : s_mem_byte_offset;
  assign ext_funct3_s = waiting_s ? cap_funct3_q : s_funct3;

  writeback_retire_unit_load_extender #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extender (
    .raw_i    (s_mem_data),
    .offset_i (ext_offset_s),
    .funct3_i (ext_funct3_s),
    .data_o   (ext_data_s)
  );

  // Next-state: handshake, load wait, and completion of one instruction.
  always_comb begin
    state_d      = state_q;
    cap_rd_d     = cap_rd_q;
    cap_funct3_d = cap_funct3_q;
    cap_offset_d = cap_offset_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    count_d      = count_q;
    case (state_q)
      ST_IDLE: begin
        if (s_tvalid) begin
          if ((s_opcode == OPCODE_LOAD) && !s_mem_data_valid) begin
            state_d      = ST_WAIT_MEM;
            cap_rd_d     = s_rd;
            cap_funct3_d = s_funct3;
            cap_offset_d = s_mem_byte_offset;
          end else begin
            // Writes to x0 still retire but never reach the register file.
            rf_we_d    = opcode_writes_rd(s_opcode) && (s_rd != RD_ZERO);
            rf_waddr_d = s_rd;
            case (opcode_wb_src(s_opcode))
              SRC_LINK: rf_wdata_d = s_link_addr;
              SRC_LOAD: rf_wdata_d = ext_data_s;
              default:  rf_wdata_d = s_alu_result;
            endcase
            count_d = count_q + COUNTER_WIDTH'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        if (s_mem_data_valid) begin
          state_d    = ST_IDLE;
          rf_we_d    = (cap_rd_q != RD_ZERO);
          rf_waddr_d = cap_rd_q;
          rf_wdata_d = ext_data_s;
          count_d    = count_q + COUNTER_WIDTH'(1);
        end else begin
          state_d = ST_WAIT_MEM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cap_rd_q     <= RD_ZERO;
      cap_funct3_q <= 3'b000;
      cap_offset_q <= 2'b00;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= RD_ZERO;
      rf_wdata_q   <= {DATA_WIDTH{1'b0}};
      count_q      <= {COUNTER_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      cap_rd_q     <= cap_rd_d;
      cap_funct3_q <= cap_funct3_d;
      cap_offset_q <= cap_offset_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      count_q      <= count_d;
    end
  end

  assign s_tready      = (state_q == ST_IDLE);
  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign pending_load  = waiting_s;
  assign pending_rd    = waiting_s ? cap_rd_q : RD_ZERO;
  assign retired_count = count_q;

  if (BYPASS_ENABLE != 0) begin : g_bypass
    assign bypass_valid = rf_we_q;
    assign bypass_rd    = rf_waddr_q;
    assign bypass_data  = rf_wdata_q;
  end else begin : g_no_bypass
    assign bypass_valid = 1'b0;
    assign bypass_rd    = RD_ZERO;
    assign bypass_data  = {DATA_WIDTH{1'b0}};
  end

endmodule

// File: tb/tb_writeback_retire_unit.sv
// -----------------------------------------------------------------------------
// tb_writeback_retire_unit
// Scoreboard bench: the stimulus pushes the expected retirement into a queue
// when an instruction completes; a negedge monitor pops and compares whenever
// retired_count moves. A second instance (4-bit counter, bypass disabled)
// shares the inputs and is checked for wrap and for silent bypass outputs.
// -----------------------------------------------------------------------------
module tb_writeback_retire_unit;
  import writeback_retire_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid;
  logic        s_tready;
  logic [6:0]  s_opcode;
  logic [2:0]  s_funct3;
  logic [4:0]  s_rd;
  logic [31:0] s_alu_result;
  logic [31:0] s_link_addr;
  logic [1:0]  s_mem_byte_offset;
  logic [31:0] s_mem_data;
  logic        s_mem_data_valid;

  logic        rf_we, bypass_valid, pending_load;
  logic [4:0]  rf_waddr, bypass_rd, pending_rd;
  logic [31:0] rf_wdata, bypass_data;
  logic [63:0] retired_count;

  logic        d2_tready, d2_rf_we, d2_bypass_valid, d2_pending_load;
  logic [4:0]  d2_rf_waddr, d2_bypass_rd, d2_pending_rd;
  logic [31:0] d2_rf_wdata, d2_bypass_data;
  logic [3:0]  d2_retired_count;

  always #5 clk = ~clk;

  writeback_retire_unit #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .COUNTER_WIDTH(64), .BYPASS_ENABLE(1)
  ) dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_opcode(s_opcode), .s_funct3(s_funct3), .s_rd(s_rd),
    .s_alu_result(s_alu_result), .s_link_addr(s_link_addr),
    .s_mem_byte_offset(s_mem_byte_offset), .s_mem_data(s_mem_data),
    .s_mem_data_valid(s_mem_data_valid),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .bypass_valid(bypass_valid), .bypass_rd(bypass_rd), .bypass_data(bypass_data),
    .pending_load(pending_load), .pending_rd(pending_rd),
    .retired_count(retired_count)
  );

  writeback_retire_unit #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .COUNTER_WIDTH(4), .BYPASS_ENABLE(0)
  ) dut_small (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(d2_tready),
    .s_opcode(s_opcode), .s_funct3(s_funct3), .s_rd(s_rd),
    .s_alu_result(s_alu_result), .s_link_addr(s_link_addr),
    .s_mem_byte_offset(s_mem_byte_offset), .s_mem_data(s_mem_data),
    .s_mem_data_valid(s_mem_data_valid),
    .rf_we(d2_rf_we), .rf_waddr(d2_rf_waddr), .rf_wdata(d2_rf_wdata),
    .bypass_valid(d2_bypass_valid), .bypass_rd(d2_bypass_rd), .bypass_data(d2_bypass_data),
    .pending_load(d2_pending_load), .pending_rd(d2_pending_rd),
    .retired_count(d2_retired_count)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [63:0] count;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [63:0] exp_count  = 64'd0;
  logic [63:0] prev_count = 64'd0;
  int          n_checks   = 0;
  int          n_pass     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every change of retired_count is one retirement to score.
  always @(negedge clk) begin
    if (rst) begin
      prev_count = 64'd0;
    end else if (retired_count != prev_count) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL retire_unexpected: got count 0x%0h expected no retirement", retired_count);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rf_we", rf_we, mon_e.we);
        chk("bypass_valid", bypass_valid, mon_e.we);
        if (mon_e.we) begin
          chk("rf_waddr", rf_waddr, mon_e.rd);
          chk("rf_wdata", rf_wdata, mon_e.data);
          chk("bypass_rd", bypass_rd, mon_e.rd);
          chk("bypass_data", bypass_data, mon_e.data);
        end
        chk("retired_count", retired_count, mon_e.count);
        chk("small_count", d2_retired_count, {60'd0, mon_e.count[3:0]});
        chk("small_bypass", {d2_bypass_valid, d2_bypass_rd, d2_bypass_data}, 64'd0);
      end
      prev_count = retired_count;
    end else if (rf_we) begin
      n_checks++;
      $display("FAIL rf_we_no_retire: got rf_we 1 expected 0");
    end
  end

  // Issue one instruction with memory data available; push its expectation.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] link, input logic [1:0] off,
                       input logic [31:0] mem, input logic exp_we, input logic [31:0] exp_data);
    s_opcode = op; s_funct3 = f3; s_rd = rd; s_alu_result = alu; s_link_addr = link;
    s_mem_byte_offset = off; s_mem_data = mem; s_mem_data_valid = 1'b1; s_tvalid = 1'b1;
    @(posedge clk);
    exp_count++;
    sb_q.push_back('{exp_we, rd, exp_data, exp_count});
    #1;
    s_tvalid = 1'b0; s_mem_data_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; s_tvalid = 1'b0; s_opcode = 7'd0; s_funct3 = 3'd0; s_rd = 5'd0;
    s_alu_result = 32'd0; s_link_addr = 32'd0; s_mem_byte_offset = 2'd0;
    s_mem_data = 32'd0; s_mem_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_tready", s_tready, 1'b1);
    chk("reset_rf", {rf_we, rf_waddr, rf_wdata}, 64'd0);
    chk("reset_bypass", {bypass_valid, bypass_rd, bypass_data}, 64'd0);
    chk("reset_pending", {pending_load, pending_rd}, 64'd0);
    chk("reset_count", retired_count, 64'd0);

    // Single ARITH: one-cycle pulse.
    issue(OPCODE_ARITHMETIC, 3'd0, 5'd5, 32'h0000_1234, 32'd0, 2'd0, 32'd0, 1'b1, 32'h0000_1234);
    @(negedge clk); chk("arith_pulse_on", rf_we, 1'b1);
    @(negedge clk); chk("arith_pulse_off", rf_we, 1'b0);

    issue(OPCODE_LOAD, FUNCT3_LB,  5'd6, 32'd0, 32'd0, 2'd2, 32'h0080_0000, 1'b1, 32'hFFFF_FF80);
    issue(OPCODE_LOAD, FUNCT3_LHU, 5'd7, 32'd0, 32'd0, 2'd2, 32'h8001_0000, 1'b1, 32'h0000_8001);
    issue(OPCODE_LOAD, FUNCT3_LBU, 5'd8, 32'd0, 32'd0, 2'd3, 32'h8000_0000, 1'b1, 32'h0000_0080);
    issue(OPCODE_LOAD, FUNCT3_LH,  5'd9, 32'd0, 32'd0, 2'd1, 32'h0000_8001, 1'b1, 32'hFFFF_8001);
    issue(OPCODE_LOAD, 3'b011,     5'd12, 32'd0, 32'd0, 2'd1, 32'h1234_5678, 1'b1, 32'h1234_5678);
    issue(OPCODE_JAL,  3'd0, 5'd0, 32'h0000_0777, 32'h0000_0104, 2'd0, 32'd0, 1'b0, 32'd0);
    issue(OPCODE_JALR, 3'd0, 5'd1, 32'h0000_0999, 32'h0000_0200, 2'd0, 32'd0, 1'b1, 32'h0000_0200);
    issue(OPCODE_STORE, 3'd2, 5'd3, 32'h0000_0040, 32'd0, 2'd0, 32'd0, 1'b0, 32'd0);
    issue(OPCODE_LUI, 3'd0, 5'd31, 32'hABCD_E000, 32'd0, 2'd0, 32'd0, 1'b1, 32'hABCD_E000);
    issue(OPCODE_ARITHMETIC, 3'd0, 5'd10, 32'h0000_00AA, 32'd0, 2'd0, 32'd0, 1'b1, 32'h0000_00AA);
    issue(OPCODE_ARITH_IMM,  3'd0, 5'd11, 32'h0000_00BB, 32'd0, 2'd0, 32'd0, 1'b1, 32'h0000_00BB);
    issue(OPCODE_BRANCH, 3'd0, 5'd4, 32'h0000_0001, 32'd0, 2'd0, 32'd0, 1'b0, 32'd0);

    // LW with late data; upstream holds an ARITH meanwhile.
    s_opcode = OPCODE_LOAD; s_funct3 = FUNCT3_LW; s_rd = 5'd13; s_mem_byte_offset = 2'd1;
    s_mem_data = 32'h0; s_mem_data_valid = 1'b0; s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_opcode = OPCODE_ARITHMETIC; s_funct3 = 3'd0; s_rd = 5'd14; s_alu_result = 32'h0000_5555;
    s_mem_byte_offset = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_tready", s_tready, 1'b0);
      chk("wait_pending", {pending_load, pending_rd}, {58'd0, 1'b1, 5'd13});
      chk("wait_no_accept", retired_count, exp_count);
    end
    s_mem_data = 32'hDEAD_BEEF; s_mem_data_valid = 1'b1;
    @(posedge clk);
    exp_count++;
    sb_q.push_back('{1'b1, 5'd13, 32'hDEAD_BEEF, exp_count});
    #1 s_mem_data_valid = 1'b0;
    @(negedge clk);
    chk("late_write", {rf_we, rf_wdata}, {31'd0, 1'b1, 32'hDEAD_BEEF});
    chk("late_released", pending_load, 1'b0);
    @(posedge clk);
    exp_count++;
    sb_q.push_back('{1'b1, 5'd14, 32'h0000_5555, exp_count});
    #1 s_tvalid = 1'b0;

    // Reset while a load waits.
    s_opcode = OPCODE_LOAD; s_funct3 = FUNCT3_LBU; s_rd = 5'd15; s_mem_byte_offset = 2'd0;
    s_mem_data_valid = 1'b0; s_tvalid = 1'b1;
    @(posedge clk);
    #1 s_tvalid = 1'b0;
    @(negedge clk); chk("rst_pre_pending", pending_load, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    sb_q.delete();
    exp_count = 64'd0;
    @(posedge clk);
    #1 rst = 1'b0; s_mem_data_valid = 1'b1;
    @(negedge clk);
    chk("rst_wait_tready", s_tready, 1'b1);
    chk("rst_wait_pending", pending_load, 1'b0);
    chk("rst_wait_no_write", rf_we, 1'b0);
    chk("rst_wait_count", retired_count, 64'd0);
    @(posedge clk);
    #1 s_mem_data_valid = 1'b0;

    // 17 retirements: small counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      issue(OPCODE_ARITHMETIC, 3'd0, 5'(i + 1), 32'(i * 3 + 1), 32'd0, 2'd0, 32'd0,
            1'b1, 32'(i * 3 + 1));
    end
    repeat (3) @(negedge clk);
    chk("count_17", retired_count, 64'd17);
    chk("small_wrap", d2_retired_count, 64'd1);
    chk("scoreboard_empty", sb_q.size(), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
